axi_burst_master: RTL and testbench

- Directed AXI4 master traffic engine for the slave-model bench; drives the AW/W/B/AR/R ports of the AXI slave + SPRAM model directly.
- Accepts one command at a time (write or read INCR burst), generates a deterministic data pattern and self-checks read data against the same pattern.
- Reports completion, response errors and mismatch counts to the testbench sequencer.

---
 rtl/axi_mst_pkg.sv | 25 ++
 rtl/axi_mst_lfsr.sv | 26 ++
 rtl/axi_burst_master.sv | 276 +++++++++++++++++++++++++++
 tb/tb_axi_burst_master.sv | 347 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_mst_pkg.sv
// Shared types and helpers for the directed AXI4 burst master.
// Holds the controller state encoding, the AXI protocol constants the master
// drives or compares against, and the per-beat data pattern generator.
package axi_mst_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    AW   = 3'd1,
    W    = 3'd2,
    B    = 3'd3,
    AR   = 3'd4,
    R    = 3'd5,
    DONE = 3'd6
  } mst_state_e;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

  // Pattern word for beat k: (seed + k) mod 2^32. The bus carries
  // AXI_DW/32 copies of this word, replicated at the point of use.
  function automatic logic [31:0] pat(input logic [31:0] seed, input logic [31:0] k);
    return seed + k;
  endfunction

endpackage

// File: rtl/axi_mst_lfsr.sv
// 16-bit Fibonacci LFSR (taps 16,14,13,11), seeded to 16'hACE1 on reset.
// Only the two low state bits leave the block; they gate the write-valid
// and read-ready handshakes when throttling is compiled in.
module axi_mst_lfsr (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  output logic [1:0] tap
);

  logic [15:0] state;
  logic        feedback;

  assign feedback = state[15] ^ state[13] ^ state[12] ^ state[10];
  assign tap      = state[1:0];

  // Shift the register by one position whenever enabled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= 16'hACE1;
    end else if (en) begin
      state <= {state[14:0], feedback};
    end
  end

endmodule

// File: rtl/axi_burst_master.sv
// Directed AXI4 master traffic engine. Takes one write or read INCR burst
// command at a time, drives a deterministic (seed + beat) data pattern on
// writes and checks read data against the same pattern, reporting a done
// pulse, a sticky response-error flag and a saturating mismatch count.
// Optional build macro AXI_MST_THROTTLE_EN: pseudo-random throttling of
// WVALID and RREADY from an internal LFSR.
module axi_burst_master
  import axi_mst_pkg::*;
#(
  parameter int AXI_DW    = 128,
  parameter int AXI_AW    = 40,
  parameter int AXI_IW    = 8,
  parameter int AXI_LW    = 8,
  parameter int AXI_SW    = 3,
  parameter int MST_ID    = 0,
  parameter int AXI_BYTES = AXI_DW / 8
) (
  input  logic                ACLK,
  input  logic                ARESET,
  // command interface
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic                cmd_write,
  input  logic [AXI_AW-1:0]   cmd_addr,
  input  logic [AXI_LW-1:0]   cmd_len,
  input  logic [31:0]         cmd_seed,
  output logic                done,
  output logic                resp_err,
  output logic [15:0]         mism_cnt,
  // write address channel
  output logic [AXI_IW-1:0]   AWID,
  output logic [AXI_AW-1:0]   AWADDR,
  output logic [AXI_LW-1:0]   AWLEN,
  output logic [AXI_SW-1:0]   AWSIZE,
  output logic [1:0]          AWBURST,
  output logic                AWLOCK,
  output logic [3:0]          AWCACHE,
  output logic [2:0]          AWPROT,
  output logic [3:0]          AWQOS,
  output logic [3:0]          AWREGION,
  output logic                AWVALID,
  input  logic                AWREADY,
  // write data channel
  output logic [AXI_DW-1:0]   WDATA,
  output logic [AXI_BYTES-1:0] WSTRB,
  output logic                WLAST,
  output logic                WVALID,
  input  logic                WREADY,
  // write response channel
  input  logic [AXI_IW-1:0]   BID,
  input  logic [1:0]          BRESP,
  input  logic                BVALID,
  output logic                BREADY,
  // read address channel
  output logic [AXI_IW-1:0]   ARID,
  output logic [AXI_AW-1:0]   ARADDR,
  output logic [AXI_LW-1:0]   ARLEN,
  output logic [AXI_SW-1:0]   ARSIZE,
  output logic [1:0]          ARBURST,
  output logic                ARLOCK,
  output logic [3:0]          ARCACHE,
  output logic [2:0]          ARPROT,
  output logic [3:0]          ARQOS,
  output logic [3:0]          ARREGION,
  output logic                ARVALID,
  input  logic                ARREADY,
  // read data channel
  input  logic [AXI_IW-1:0]   RID,
  input  logic [AXI_DW-1:0]   RDATA,
  input  logic [1:0]          RRESP,
  input  logic                RLAST,
  input  logic                RVALID,
  output logic                RREADY
);

  localparam int                WORDS    = AXI_DW / 32;
  localparam logic [AXI_IW-1:0] ID_VAL   = AXI_IW'(MST_ID);
  localparam logic [AXI_SW-1:0] SIZE_VAL = AXI_SW'($clog2(AXI_BYTES));

  mst_state_e          state;
  mst_state_e          state_nxt;

  logic [AXI_AW-1:0]   addr_q;
  logic [AXI_LW-1:0]   len_q;
  logic [31:0]         seed_q;
  logic [AXI_IW-1:0]   id_q;
  logic [AXI_SW-1:0]   size_q;
  logic [1:0]          burst_q;
  logic [AXI_LW-1:0]   beat;

  logic                accept;
  logic                w_fire;
  logic                b_fire;
  logic                r_fire;
  logic                beat_is_last;
  logic [31:0]         exp_word;
  logic [AXI_DW-1:0]   exp_data;
  logic                data_bad;
  logic                last_bad;
  logic [1:0]          mism_inc;
  logic [16:0]         mism_sum;
  logic                wvalid_gate;
  logic                rready_gate;

  assign accept       = (state == IDLE) && cmd_valid;
  assign w_fire       = WVALID && WREADY;
  assign b_fire       = BVALID && BREADY;
  assign r_fire       = RVALID && RREADY;
  assign beat_is_last = (beat == len_q);

  assign exp_word = pat(seed_q, 32'(beat));
  assign exp_data = {WORDS{exp_word}};

  assign data_bad = (RDATA != exp_data);
  assign last_bad = (RLAST != beat_is_last);
  assign mism_inc = {1'b0, data_bad} + {1'b0, last_bad};
  assign mism_sum = {1'b0, mism_cnt} + 17'(mism_inc);

`ifdef AXI_MST_THROTTLE_EN
  logic [1:0] lfsr_tap;
  logic       wvalid_q;

  axi_mst_lfsr u_lfsr (
    .clk (ACLK),
    .rst (ARESET),
    .en  (1'b1),
    .tap (lfsr_tap)
  );

  // Raise WVALID for a new beat only on an LFSR "go", then hold until accepted.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      wvalid_q <= 1'b0;
    end else if (state == W) begin
      if (wvalid_q && WREADY) begin
        wvalid_q <= 1'b0;
      end else if (!wvalid_q && lfsr_tap[0]) begin
        wvalid_q <= 1'b1;
      end
    end else begin
      wvalid_q <= 1'b0;
    end
  end

  assign wvalid_gate = wvalid_q;
  assign rready_gate = lfsr_tap[1];
`else
  assign wvalid_gate = 1'b1;
  assign rready_gate = 1'b1;
`endif

  // Static channel fields and the per-beat write payload.
  assign AWID     = id_q;
  assign AWADDR   = addr_q;
  assign AWLEN    = len_q;
  assign AWSIZE   = size_q;
  assign AWBURST  = burst_q;
  assign AWLOCK   = 1'b0;
  assign AWCACHE  = 4'd0;
  assign AWPROT   = 3'd0;
  assign AWQOS    = 4'd0;
  assign AWREGION = 4'd0;

  assign ARID     = id_q;
  assign ARADDR   = addr_q;
  assign ARLEN    = len_q;
  assign ARSIZE   = size_q;
  assign ARBURST  = burst_q;
  assign ARLOCK   = 1'b0;
  assign ARCACHE  = 4'd0;
  assign ARPROT   = 3'd0;
  assign ARQOS    = 4'd0;
  assign ARREGION = 4'd0;

  assign WDATA = exp_data;
  assign WSTRB = '1;
  assign WLAST = (state == W) && beat_is_last;

  // Controller state register.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state selection from the channel handshakes.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (cmd_valid) state_nxt = cmd_write ? AW : AR;
      AW:   if (AWREADY) state_nxt = W;
      W:    if (w_fire && beat_is_last) state_nxt = B;
      B:    if (BVALID) state_nxt = DONE;
      AR:   if (ARREADY) state_nxt = R;
      R:    if (r_fire && (RLAST || beat_is_last)) state_nxt = DONE;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Handshake outputs decoded from the current state.
  always_comb begin
    cmd_ready = 1'b0;
    AWVALID   = 1'b0;
    WVALID    = 1'b0;
    BREADY    = 1'b0;
    ARVALID   = 1'b0;
    RREADY    = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE:    cmd_ready = 1'b1;
      AW:      AWVALID   = 1'b1;
      W:       WVALID    = wvalid_gate;
      B:       BREADY    = 1'b1;
      AR:      ARVALID   = 1'b1;
      R:       RREADY    = rready_gate;
      DONE:    done      = 1'b1;
      default: ;
    endcase
  end

  // Capture the command fields once, when the command is accepted.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      addr_q  <= '0;
      len_q   <= '0;
      seed_q  <= '0;
      id_q    <= '0;
      size_q  <= '0;
      burst_q <= '0;
    end else if (accept) begin
      addr_q  <= cmd_addr;
      len_q   <= cmd_len;
      seed_q  <= cmd_seed;
      id_q    <= ID_VAL;
      size_q  <= SIZE_VAL;
      burst_q <= AXI_BURST_INCR;
    end
  end

  // Beat index: restarts per command, advances on each accepted data beat.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      beat <= '0;
    end else if (accept) begin
      beat <= '0;
    end else if ((state == W && w_fire) || (state == R && r_fire)) begin
      beat <= beat + 1'b1;
    end
  end

  // Saturating mismatch counter, cleared when a new command is accepted.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      mism_cnt <= '0;
    end else if (accept) begin
      mism_cnt <= '0;
    end else if (state == R && r_fire) begin
      mism_cnt <= mism_sum[16] ? 16'hFFFF : mism_sum[15:0];
    end
  end

  // Sticky error on any non-OKAY response or foreign ID; only reset clears it.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      resp_err <= 1'b0;
    end else if (state == B && b_fire && (BRESP != AXI_RESP_OKAY || BID != ID_VAL)) begin
      resp_err <= 1'b1;
    end else if (state == R && r_fire && (RRESP != AXI_RESP_OKAY || RID != ID_VAL)) begin
      resp_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_axi_burst_master.sv
// Self-checking bench for axi_burst_master. The bench plays the AXI slave
// with randomized handshake timing, keeps a beat-addressed memory of what was
// written, and predicts write data, WLAST, mismatch counts and the sticky
// error flag from the (seed + beat) pattern rule.
module tb_axi_burst_master;

  localparam int DW = 128;
  localparam int AW = 40;

  logic            ACLK;
  logic            ARESET;
  logic            cmd_valid;
  logic            cmd_ready;
  logic            cmd_write;
  logic [AW-1:0]   cmd_addr;
  logic [7:0]      cmd_len;
  logic [31:0]     cmd_seed;
  logic            done;
  logic            resp_err;
  logic [15:0]     mism_cnt;
  logic [7:0]      AWID, ARID, BID, RID;
  logic [AW-1:0]   AWADDR, ARADDR;
  logic [7:0]      AWLEN, ARLEN;
  logic [2:0]      AWSIZE, ARSIZE;
  logic [1:0]      AWBURST, ARBURST;
  logic            AWLOCK, ARLOCK;
  logic [3:0]      AWCACHE, ARCACHE, AWQOS, ARQOS, AWREGION, ARREGION;
  logic [2:0]      AWPROT, ARPROT;
  logic            AWVALID, AWREADY, ARVALID, ARREADY;
  logic [DW-1:0]   WDATA, RDATA;
  logic [DW/8-1:0] WSTRB;
  logic            WLAST, WVALID, WREADY;
  logic [1:0]      BRESP, RRESP;
  logic            BVALID, BREADY;
  logic            RLAST, RVALID, RREADY;

  int checks = 0;
  int errors = 0;
  bit expErr = 0;
  logic [DW-1:0] mem [longint];

  axi_burst_master dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_seed(cmd_seed),
    .done(done), .resp_err(resp_err), .mism_cnt(mism_cnt),
    .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWBURST(AWBURST),
    .AWLOCK(AWLOCK), .AWCACHE(AWCACHE), .AWPROT(AWPROT), .AWQOS(AWQOS), .AWREGION(AWREGION),
    .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
    .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARBURST(ARBURST),
    .ARLOCK(ARLOCK), .ARCACHE(ARCACHE), .ARPROT(ARPROT), .ARQOS(ARQOS), .ARREGION(ARREGION),
    .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY)
  );

  // Free-running 100 MHz clock.
  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  // Count one comparison and report it when observed and expected differ.
  task automatic checkOutput(input string tag, input logic [DW-1:0] actual, input logic [DW-1:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Expected bus value for beat b of a burst with the given seed.
  function automatic logic [DW-1:0] patBus(input logic [31:0] seed, input int b);
    logic [31:0] word;
    word = seed + 32'(b);
    return {4{word}};
  endfunction

  function automatic longint memKey(input logic [AW-1:0] addr, input int b);
    return longint'(addr >> 4) + longint'(b);
  endfunction

  // Present one command for a single cycle from IDLE.
  task automatic applyStimulus(input bit wr, input logic [AW-1:0] addr, input logic [7:0] len,
                               input logic [31:0] seed);
    @(negedge ACLK);
    checkOutput("cmd_ready_idle", cmd_ready, 1'b1);
    cmd_valid = 1'b1;
    cmd_write = wr;
    cmd_addr  = addr;
    cmd_len   = len;
    cmd_seed  = seed;
    @(negedge ACLK);
    cmd_valid = 1'b0;
    checkOutput("mism_clr", mism_cnt, 16'd0);
  endtask

  // Address phase of a write: optional AWREADY stall with stability checks.
  task automatic awPhase(input logic [AW-1:0] addr, input logic [7:0] len, input int stall);
    int t = 0;
    while (AWVALID !== 1'b1 && t < 20) begin @(negedge ACLK); t++; end
    checkOutput("aw_valid", AWVALID, 1'b1);
    checkOutput("aw_addr", AWADDR, addr);
    checkOutput("aw_len", AWLEN, len);
    checkOutput("aw_size", AWSIZE, 3'd4);
    checkOutput("aw_burst", AWBURST, 2'b01);
    checkOutput("aw_id", AWID, 8'd0);
    checkOutput("w_before_aw", WVALID, 1'b0);
    for (int s = 0; s < stall; s++) begin
      if (s == 0 && stall >= 2) begin
        cmd_valid = 1'b1;
        cmd_write = 1'b0;
      end
      @(negedge ACLK);
      cmd_valid = 1'b0;
      checkOutput("aw_hold", AWVALID, 1'b1);
      checkOutput("aw_addr_hold", AWADDR, addr);
      checkOutput("aw_stall_nowv", WVALID, 1'b0);
      checkOutput("busy_cmd_ready", cmd_ready, 1'b0);
    end
    AWREADY = 1'b1;
    @(negedge ACLK);
    AWREADY = 1'b0;
    checkOutput("aw_drop", AWVALID, 1'b0);
  endtask

  // Address phase of a read.
  task automatic arPhase(input logic [AW-1:0] addr, input logic [7:0] len, input int stall);
    int t = 0;
    while (ARVALID !== 1'b1 && t < 20) begin @(negedge ACLK); t++; end
    checkOutput("ar_valid", ARVALID, 1'b1);
    checkOutput("ar_addr", ARADDR, addr);
    checkOutput("ar_len", ARLEN, len);
    checkOutput("ar_size", ARSIZE, 3'd4);
    checkOutput("ar_burst", ARBURST, 2'b01);
    for (int s = 0; s < stall; s++) begin
      @(negedge ACLK);
      checkOutput("ar_hold", ARVALID, 1'b1);
      checkOutput("ar_addr_hold", ARADDR, addr);
    end
    ARREADY = 1'b1;
    @(negedge ACLK);
    ARREADY = 1'b0;
  endtask

  // Accept up to maxBeats write beats with random WREADY, checking each one.
  task automatic wPhase(input logic [AW-1:0] addr, input logic [7:0] len, input logic [31:0] seed,
                        input int maxBeats);
    int b = 0;
    int t = 0;
    while (b < maxBeats && t < 4000) begin
      if (WVALID === 1'b1 && $urandom_range(0, 3) != 0) begin
        WREADY = 1'b1;
        checkOutput("w_data", WDATA, patBus(seed, b));
        checkOutput("w_last", WLAST, (b == int'(len)));
        checkOutput("w_strb", WSTRB, {(DW/8){1'b1}});
        mem[memKey(addr, b)] = WDATA;
        b++;
      end else begin
        WREADY = 1'b0;
      end
      @(negedge ACLK);
      t++;
    end
    WREADY = 1'b0;
    if (b < maxBeats) checkOutput("w_timeout", 32'(b), 32'(maxBeats));
  endtask

  // One cycle of done, then back to IDLE.
  task automatic checkDone();
    checkOutput("done_pulse", done, 1'b1);
    checkOutput("done_busy", cmd_ready, 1'b0);
    @(negedge ACLK);
    checkOutput("done_clear", done, 1'b0);
    checkOutput("idle_ready", cmd_ready, 1'b1);
  endtask

  task automatic bPhase(input logic [1:0] bresp, input logic [7:0] bid);
    int t = 0;
    checkOutput("w_after_last", WVALID, 1'b0);
    while (BREADY !== 1'b1 && t < 20) begin @(negedge ACLK); t++; end
    checkOutput("b_ready", BREADY, 1'b1);
    BVALID = 1'b1;
    BRESP  = bresp;
    BID    = bid;
    @(negedge ACLK);
    BVALID = 1'b0;
    BRESP  = 2'b00;
    BID    = 8'd0;
    checkDone();
  endtask

  // Return beats from memory; lastAt chooses which beat carries RLAST.
  task automatic rPhase(input logic [AW-1:0] addr, input logic [7:0] len, input logic [31:0] seed,
                        input int lastAt, input logic [1:0] rresp, input logic [7:0] rid,
                        output int expMism);
    int b = 0;
    int t = 0;
    bit fin = 0;
    bit lastFlag;
    logic [DW-1:0] d;
    expMism = 0;
    while (!fin && t < 4000) begin
      if ($urandom_range(0, 3) == 0) begin
        RVALID = 1'b0;
        @(negedge ACLK);
        t++;
      end else begin
        d = mem.exists(memKey(addr, b)) ? mem[memKey(addr, b)] : '0;
        lastFlag = (b == lastAt);
        RVALID = 1'b1;
        RDATA  = d;
        RLAST  = lastFlag;
        RRESP  = rresp;
        RID    = rid;
        while (RREADY !== 1'b1 && t < 4000) begin @(negedge ACLK); t++; end
        @(negedge ACLK);
        t++;
        if (d !== patBus(seed, b)) expMism++;
        if (lastFlag != (b == int'(len))) expMism++;
        if (lastFlag || b == int'(len)) fin = 1;
        b++;
      end
    end
    RVALID = 1'b0;
    RLAST  = 1'b0;
    RRESP  = 2'b00;
    RID    = 8'd0;
    RDATA  = '0;
    if (!fin) checkOutput("r_timeout", 1'b0, 1'b1);
  endtask

  task automatic doWrite(input logic [AW-1:0] addr, input logic [7:0] len, input logic [31:0] seed,
                         input int stall, input logic [1:0] bresp, input logic [7:0] bid);
    applyStimulus(1'b1, addr, len, seed);
    awPhase(addr, len, stall);
    wPhase(addr, len, seed, int'(len) + 1);
    bPhase(bresp, bid);
    if (bresp != 2'b00 || bid != 8'd0) expErr = 1'b1;
    checkOutput("resp_err_w", resp_err, expErr);
  endtask

  task automatic doRead(input logic [AW-1:0] addr, input logic [7:0] len, input logic [31:0] seed,
                        input int lastAt, input logic [1:0] rresp, input logic [7:0] rid,
                        input int stall);
    int expMism;
    applyStimulus(1'b0, addr, len, seed);
    arPhase(addr, len, stall);
    rPhase(addr, len, seed, lastAt, rresp, rid, expMism);
    checkDone();
    checkOutput("mism_cnt", mism_cnt, 16'(expMism));
    if (rresp != 2'b00 || rid != 8'd0) expErr = 1'b1;
    checkOutput("resp_err_r", resp_err, expErr);
  endtask

  // Test sequence.
  initial begin
    logic [AW-1:0] ra;
    logic [7:0]    rl;
    logic [31:0]   rs;

    ARESET = 1'b1;
    cmd_valid = 0; cmd_write = 0; cmd_addr = '0; cmd_len = '0; cmd_seed = '0;
    AWREADY = 0; WREADY = 0; BVALID = 0; BRESP = 0; BID = 0;
    ARREADY = 0; RVALID = 0; RDATA = '0; RRESP = 0; RLAST = 0; RID = 0;
    repeat (3) @(negedge ACLK);

    $display("[TB] reset state");
    checkOutput("rst_awvalid", AWVALID, 1'b0);
    checkOutput("rst_wvalid", WVALID, 1'b0);
    checkOutput("rst_arvalid", ARVALID, 1'b0);
    checkOutput("rst_bready", BREADY, 1'b0);
    checkOutput("rst_rready", RREADY, 1'b0);
    checkOutput("rst_done", done, 1'b0);
    checkOutput("rst_resp_err", resp_err, 1'b0);
    checkOutput("rst_mism", mism_cnt, 16'd0);
    checkOutput("rst_awaddr", AWADDR, '0);
    checkOutput("rst_wdata", WDATA, '0);
    checkOutput("rst_cache", {AWLOCK, AWCACHE, AWPROT, ARLOCK, ARCACHE, ARPROT}, '0);
    ARESET = 1'b0;
    @(negedge ACLK);
    checkOutput("rst_cmd_ready", cmd_ready, 1'b1);

    $display("[TB] directed bursts");
    doWrite(40'h100, 8'd3, 32'h10, 5, 2'b00, 8'd0);
    doRead(40'h100, 8'd3, 32'h10, 3, 2'b00, 8'd0, 2);
    checkOutput("tp_read_same", mism_cnt, 16'd0);
    doRead(40'h100, 8'd3, 32'h11, 3, 2'b00, 8'd0, 0);
    checkOutput("tp_read_other", mism_cnt, 16'd4);
    doWrite(40'h0, 8'd0, 32'hFFFF_FFFF, 0, 2'b00, 8'd0);
    doRead(40'h0, 8'd0, 32'hFFFF_FFFF, 0, 2'b00, 8'd0, 1);
    checkOutput("tp_len0", mism_cnt, 16'd0);
    doRead(40'h100, 8'd3, 32'h10, 1, 2'b00, 8'd0, 0);
    checkOutput("tp_early_rlast", mism_cnt, 16'd1);
    doRead(40'h100, 8'd3, 32'h10, 99, 2'b00, 8'd0, 0);
    checkOutput("tp_missing_rlast", mism_cnt, 16'd1);

    $display("[TB] randomized bursts");
    for (int i = 0; i < 10; i++) begin
      ra = 40'($urandom_range(0, 255)) << 4;
      rl = (i == 5) ? 8'd255 : 8'($urandom_range(0, 15));
      rs = $urandom;
      doWrite(ra, rl, rs, $urandom_range(0, 3), 2'b00, 8'd0);
      if ($urandom_range(0, 1) == 0) rs = $urandom;
      doRead(ra, rl, rs, int'(rl), 2'b00, 8'd0, $urandom_range(0, 3));
    end

    $display("[TB] response errors");
    doWrite(40'h200, 8'd1, 32'h55, 0, 2'b10, 8'd0);
    checkOutput("tp_bresp_err", resp_err, 1'b1);
    doRead(40'h200, 8'd1, 32'h55, 1, 2'b00, 8'd0, 0);
    checkOutput("tp_err_sticky", resp_err, 1'b1);

    $display("[TB] reset during write burst");
    applyStimulus(1'b1, 40'h300, 8'd7, 32'hABCD);
    awPhase(40'h300, 8'd7, 0);
    wPhase(40'h300, 8'd7, 32'hABCD, 2);
    ARESET = 1'b1;
    #1;
    checkOutput("mid_awvalid", AWVALID, 1'b0);
    checkOutput("mid_wvalid", WVALID, 1'b0);
    checkOutput("mid_arvalid", ARVALID, 1'b0);
    checkOutput("mid_done", done, 1'b0);
    checkOutput("mid_resp_err", resp_err, 1'b0);
    @(negedge ACLK);
    ARESET = 1'b0;
    expErr = 1'b0;
    @(negedge ACLK);
    checkOutput("mid_cmd_ready", cmd_ready, 1'b1);
    checkOutput("mid_wvalid_after", WVALID, 1'b0);
    checkOutput("mid_awaddr", AWADDR, '0);

    doWrite(40'h400, 8'd2, 32'h1234, 1, 2'b00, 8'd0);
    doRead(40'h400, 8'd2, 32'h1234, 2, 2'b00, 8'd3, 0);
    checkOutput("tp_rid_err", resp_err, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
